alu_seq: RTL

//  Parametrised, handshaked successor to the 6-bit combinational ALU. Adds SUB, logic ops,

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_iter.sv | 61 ++++++
 rtl/alu_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state encodings for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Bit positions inside the {Z,N,C,V} flag vector
  localparam int unsigned F_Z = 3;
  localparam int unsigned F_N = 2;
  localparam int unsigned F_C = 1;
  localparam int unsigned F_V = 0;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StBusy = 2'd1;
  localparam state_t StDone = 2'd2;

  function automatic logic [3:0] pack_flags(input logic z, input logic n, input logic c,
                                            input logic v);
    logic [3:0] f;
    f      = '0;
    f[F_Z] = z;
    f[F_N] = n;
    f[F_C] = c;
    f[F_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, W steps per product.
module alu_mul_iter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] mcand_i,
  input  logic [W-1:0] mplier_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] product_o
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    acc_step;

  // Only the low W bits are kept; upper partial-product bits never reach the result
  assign acc_step  = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign busy_o    = (cnt_q != '0);
  assign done_o    = busy_o && (cnt_q == CntW'(1));
  assign product_o = acc_step;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      cnt_d    = CntW'(W);
    end else if (busy_o) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops register at accept, MUL runs on the iterative engine.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W   = 6,
  parameter int unsigned SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] op1_i,
  input  logic [W-1:0] op2_i,
  input  logic [2:0]   alu_fun_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] alu_out_o,
  output logic [3:0]   flags_o
);

  state_t       state_q, state_d;
  logic [W-1:0] res_q, res_d;
  logic [3:0]   flags_q, flags_d;

  logic [W:0]   a_ext, sum, diff, shl_ext;
  logic [W-1:0] dp_res;
  logic         dp_c, dp_v;
  logic [3:0]   dp_flags, mul_flags;

  logic         mul_start, mul_busy, mul_done;
  logic [W-1:0] mul_product;

  alu_mul_iter #(
    .W(W)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start),
    .mcand_i  (op1_i),
    .mplier_i (op2_i),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  // One extra bit on top catches the carry (ADD/SUB) and the last bit shifted out (SHL)
  assign a_ext   = {1'b0, op1_i};
  assign sum     = a_ext + {1'b0, op2_i};
  assign diff    = a_ext + {1'b0, ~op2_i} + (W + 1)'(1);
  assign shl_ext = a_ext << op2_i[SHW-1:0];

  always_comb begin
    dp_res = '0;
    dp_c   = 1'b0;
    dp_v   = 1'b0;
    unique case (alu_fun_i)
      OP_ADD: begin
        dp_res = sum[W-1:0];
        dp_c   = sum[W];
        dp_v   = (op1_i[W-1] == op2_i[W-1]) && (sum[W-1] != op1_i[W-1]);
      end
      OP_SUB: begin
        dp_res = diff[W-1:0];
        dp_c   = diff[W];
        dp_v   = (op1_i[W-1] != op2_i[W-1]) && (diff[W-1] != op1_i[W-1]);
      end
      OP_NOT: dp_res = ~op1_i;
      OP_AND: dp_res = op1_i & op2_i;
      OP_OR:  dp_res = op1_i | op2_i;
      OP_XOR: dp_res = op1_i ^ op2_i;
      OP_SHL: begin
        dp_res = shl_ext[W-1:0];
        dp_c   = shl_ext[W];
      end
      OP_MUL: dp_res = '0;
      default: dp_res = '0;
    endcase
  end

  assign dp_flags  = pack_flags(dp_res == '0, dp_res[W-1], dp_c, dp_v);
  assign mul_flags = pack_flags(mul_product == '0, mul_product[W-1], 1'b0, 1'b0);

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          if (alu_fun_i == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = StBusy;
          end else begin
            res_d   = dp_res;
            flags_d = dp_flags;
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        if (mul_done) begin
          res_d   = mul_product;
          flags_d = mul_flags;
          state_d = StDone;
        end else if (!mul_busy) begin
          // Engine idle without a result: never expected, recover rather than hang
          state_d = StIdle;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign alu_out_o   = res_q;
  assign flags_o     = flags_q;

endmodule
